// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter: data width,
// default oversample ratio and receiver state encodings.
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Resets to 1 so an idle-high serial line never looks like a start bit.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, driven by an oversample tick.
// Optional parity bit with UART_RX_PARITY_EN (odd parity with UART_RX_PARITY_ODD).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ack,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int                CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_W - 1);

  logic rxS;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bitIdx_q, bitIdx_d;
  logic [DATA_W-1:0]  shReg_q, shReg_d;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q;
  logic               overrun_q;
  logic               frameErr_q, frameErr_d;
  logic               deliver;

`ifdef UART_RX_PARITY_EN
  logic parBad_q, parBad_d;
  logic parityErr_q, parityErr_d;
  logic parExp;
`ifdef UART_RX_PARITY_ODD
  assign parExp = ~(^shReg_q);
`else
  assign parExp = ^shReg_q;
`endif
`endif

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rx),
    .q_o  (rxS)
  );

  // Frame sequencing; every decision is gated by tick so the FSM is paced by the bit clock.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shReg_d    = shReg_q;
    frameErr_d = 1'b0;
    deliver    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parBad_d    = parBad_q;
    parityErr_d = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rxS) begin
            state_d = START;
            cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
            parBad_d = 1'b0;
`endif
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            // Still low at mid-bit: a real start bit, otherwise a glitch.
            if (!rxS) begin
              state_d  = DATA;
              cnt_d    = '0;
              bitIdx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == CNT_MAX) begin
            shReg_d  = {rxS, shReg_q[DATA_W-1:1]};
            cnt_d    = '0;
            bitIdx_d = bitIdx_q + 3'd1;
            if (bitIdx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d       = '0;
            parBad_d    = (rxS != parExp);
            parityErr_d = (rxS != parExp);
            state_d     = STOP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (rxS) begin
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              deliver = !parBad_q;
`else
              deliver = 1'b1;
`endif
            end else begin
              frameErr_d = 1'b1;
              state_d    = BRK_WAIT;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        BRK_WAIT: begin
          // Hold off until the line is released so a break reports only once.
          if (rxS) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shReg_q    <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shReg_q    <= shReg_d;
      frameErr_q <= frameErr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parBad_q    <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      parBad_q    <= parBad_d;
      parityErr_q <= parityErr_d;
    end
  end
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

  // Holding register: an ack coinciding with a delivery frees the old byte, so no overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (deliver) begin
        data_q  <= shReg_q;
        valid_q <= 1'b1;
      end else if (ack && valid_q) begin
        valid_q <= 1'b0;
      end
      if (deliver && valid_q && !ack) begin
        overrun_q <= 1'b1;
      end else if (ack && valid_q) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frameErr_q;
  assign busy      = (state_q != IDLE);

endmodule
